ldtu_word_decoder: RTL and testbench



---
 rtl/ldtu_dec_pkg.sv | 53 +++++
 rtl/ldtu_dec_classify.sv | 30 +++
 rtl/ldtu_word_decoder.sv | 152 +++++++++++++++
 tb/tb_ldtu_word_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldtu_dec_pkg.sv
// Shared constants, word classes and unpack helper for the LiTE-DTU word decoder.
// Optional statistics counters in the top are enabled with LDTU_DEC_STATS_EN.
package ldtu_dec_pkg;

  localparam int unsigned Nbits_32     = 32;
  localparam int unsigned Nbits_12     = 12;
  localparam int unsigned FrameCntBits = 8;
  localparam int unsigned SampleW      = Nbits_12 + 1;
  localparam int unsigned BslW         = 6;
  localparam int unsigned MaxSamples   = 5;
  localparam int unsigned ShiftW       = SampleW * MaxSamples;
  localparam int unsigned RemW         = 3;
  localparam int unsigned StatW        = 16;

  localparam logic [1:0]          HDR_BSL   = 2'b01;
  localparam logic [5:0]          HDR_SIG2  = 6'b001010;
  localparam logic [5:0]          HDR_SIG1  = 6'b001011;
  localparam logic [3:0]          HDR_FRM   = 4'b1101;
  localparam logic [Nbits_32-1:0] IDLE_WORD = 32'hEAAAAAAA;

  typedef enum logic [2:0] {
    KIND_BSL,
    KIND_SIG2,
    KIND_SIG1,
    KIND_FRM,
    KIND_IDLE,
    KIND_BAD
  } word_kind_t;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  // Lay out the samples of a data word oldest-first from bit 0 of the shift register.
  function automatic logic [ShiftW-1:0] unpack_word(input logic [Nbits_32-1:0] w,
                                                    input word_kind_t kind);
    logic [ShiftW-1:0] sr;
    sr = '0;
    case (kind)
      KIND_BSL: begin
        for (int unsigned i = 0; i < MaxSamples; i++) begin
          sr[i*SampleW +: SampleW] = SampleW'(w[i*BslW +: BslW]);
        end
      end
      KIND_SIG2: sr[2*SampleW-1:0] = w[2*SampleW-1:0];
      KIND_SIG1: sr[SampleW-1:0]   = w[SampleW-1:0];
      default:   sr = '0;
    endcase
    return sr;
  endfunction

endpackage

// File: rtl/ldtu_dec_classify.sv
// Combinational header decode: word class and number of samples it carries.
module ldtu_dec_classify
  import ldtu_dec_pkg::*;
(
  input  logic [Nbits_32-1:0] word_i,
  output word_kind_t          kind_c_o,
  output logic [RemW-1:0]     nsamp_c_o
);

  // Header priority: baseline, two-sample, one-sample, delimiter, idle, anything else.
  always_comb begin
    kind_c_o  = KIND_BAD;
    nsamp_c_o = RemW'(0);
    if (word_i[31:30] == HDR_BSL) begin
      kind_c_o  = KIND_BSL;
      nsamp_c_o = RemW'(MaxSamples);
    end else if (word_i[31:26] == HDR_SIG2) begin
      kind_c_o  = KIND_SIG2;
      nsamp_c_o = RemW'(2);
    end else if (word_i[31:26] == HDR_SIG1) begin
      kind_c_o  = KIND_SIG1;
      nsamp_c_o = RemW'(1);
    end else if (word_i[31:28] == HDR_FRM) begin
      kind_c_o  = KIND_FRM;
    end else if (word_i == IDLE_WORD) begin
      kind_c_o  = KIND_IDLE;
    end
  end

endmodule

// File: rtl/ldtu_word_decoder.sv
// Receive-side unpacker for the LiTE-DTU 32-bit word stream with frame-count checking.
// Define LDTU_DEC_STATS_EN to add saturating word / error statistics outputs.
module ldtu_word_decoder
  import ldtu_dec_pkg::*;
(
  input  logic                    CLK_A,
  input  logic                    reset_A,
  input  logic [Nbits_32-1:0]     word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [SampleW-1:0]      sample_out,
  output logic                    sample_bsl,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    frame_done,
  output logic                    frame_error,
  output logic                    word_error,
  output logic [FrameCntBits-1:0] frame_cnt
`ifdef LDTU_DEC_STATS_EN
  ,
  output logic [StatW-1:0]        stat_words,
  output logic [StatW-1:0]        stat_word_err,
  output logic [StatW-1:0]        stat_frame_err
`endif
);

  state_t                  state_q;
  logic [ShiftW-1:0]       sr_q;
  logic [RemW-1:0]         rem_q;
  logic                    bsl_q;
  logic [FrameCntBits-1:0] cnt_q;
  logic [FrameCntBits-1:0] frame_cnt_q;
  logic                    frame_done_q;
  logic                    frame_error_q;
  logic                    word_error_q;

  word_kind_t              kind;
  logic [RemW-1:0]         nsamp;
  logic                    smp_acc;
  logic                    last_acc;
  logic                    word_acc;
  logic                    data_acc;
  logic                    frm_acc;
  logic                    bad_acc;
  logic                    frm_mismatch;
  logic [ShiftW-1:0]       sr_shift_d;
  logic [FrameCntBits-1:0] cnt_inc_d;

  ldtu_dec_classify u_classify (
    .word_i    (word_in),
    .kind_c_o  (kind),
    .nsamp_c_o (nsamp)
  );

  // Handshake decode; the last pending sample frees the input in the same cycle.
  always_comb begin
    smp_acc      = (state_q == S_EMIT) && sample_ready;
    last_acc     = smp_acc && (rem_q == RemW'(1));
    word_ready   = !reset_A && ((state_q == S_IDLE) || last_acc);
    word_acc     = word_valid && word_ready;
    data_acc     = word_acc && (nsamp != RemW'(0));
    frm_acc      = word_acc && (kind == KIND_FRM);
    bad_acc      = word_acc && (kind == KIND_BAD);
    frm_mismatch = cnt_q != word_in[27 -: FrameCntBits];
    sr_shift_d   = {{SampleW{1'b0}}, sr_q[ShiftW-1:SampleW]};
    cnt_inc_d    = (cnt_q == {FrameCntBits{1'b1}}) ? cnt_q : cnt_q + FrameCntBits'(1);
  end

  always_ff @(posedge CLK_A) begin
    if (reset_A) begin
      state_q       <= S_IDLE;
      sr_q          <= '0;
      rem_q         <= '0;
      bsl_q         <= 1'b0;
      cnt_q         <= '0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      word_error_q  <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      word_error_q  <= bad_acc;

      if (data_acc) begin
        state_q <= S_EMIT;
        sr_q    <= unpack_word(word_in, kind);
        rem_q   <= nsamp;
        bsl_q   <= (kind == KIND_BSL);
      end else if (last_acc) begin
        state_q <= S_IDLE;
        sr_q    <= '0;
        rem_q   <= '0;
        bsl_q   <= 1'b0;
      end else if (smp_acc) begin
        sr_q    <= sr_shift_d;
        rem_q   <= rem_q - RemW'(1);
      end

      // A sample accepted alongside a delimiter belongs to the next frame.
      if (frm_acc) begin
        frame_done_q  <= 1'b1;
        frame_cnt_q   <= cnt_q;
        frame_error_q <= frm_mismatch;
        cnt_q         <= smp_acc ? FrameCntBits'(1) : FrameCntBits'(0);
      end else if (smp_acc) begin
        cnt_q <= cnt_inc_d;
      end
    end
  end

  assign sample_out   = sr_q[SampleW-1:0];
  assign sample_bsl   = bsl_q;
  assign sample_valid = (state_q == S_EMIT);
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;
  assign word_error   = word_error_q;
  assign frame_cnt    = frame_cnt_q;

`ifdef LDTU_DEC_STATS_EN
  logic [StatW-1:0] stat_words_q;
  logic [StatW-1:0] stat_word_err_q;
  logic [StatW-1:0] stat_frame_err_q;
  logic             nonidle_acc;

  assign nonidle_acc = word_acc && (kind != KIND_IDLE);

  // Saturating counters, each advancing in the cycle its event is decided.
  always_ff @(posedge CLK_A) begin
    if (reset_A) begin
      stat_words_q     <= '0;
      stat_word_err_q  <= '0;
      stat_frame_err_q <= '0;
    end else begin
      if (nonidle_acc && (stat_words_q != {StatW{1'b1}})) begin
        stat_words_q <= stat_words_q + StatW'(1);
      end
      if (bad_acc && (stat_word_err_q != {StatW{1'b1}})) begin
        stat_word_err_q <= stat_word_err_q + StatW'(1);
      end
      if (frm_acc && frm_mismatch && (stat_frame_err_q != {StatW{1'b1}})) begin
        stat_frame_err_q <= stat_frame_err_q + StatW'(1);
      end
    end
  end

  assign stat_words     = stat_words_q;
  assign stat_word_err  = stat_word_err_q;
  assign stat_frame_err = stat_frame_err_q;
`endif

endmodule

// File: tb/tb_ldtu_word_decoder.sv
// Scoreboard bench for ldtu_word_decoder: directed cases plus randomized word stream.
`timescale 1ns/1ps
module tb_ldtu_word_decoder;

  logic        CLK_A = 1'b0;
  logic        reset_A = 1'b1;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [12:0] sample_out;
  logic        sample_bsl;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        frame_done;
  logic        frame_error;
  logic        word_error;
  logic [7:0]  frame_cnt;
`ifdef LDTU_DEC_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_word_err;
  logic [15:0] stat_frame_err;
`endif

  ldtu_word_decoder dut (
    .CLK_A        (CLK_A),
    .reset_A      (reset_A),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .sample_out   (sample_out),
    .sample_bsl   (sample_bsl),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .word_error   (word_error),
    .frame_cnt    (frame_cnt)
`ifdef LDTU_DEC_STATS_EN
    ,
    .stat_words     (stat_words),
    .stat_word_err  (stat_word_err),
    .stat_frame_err (stat_frame_err)
`endif
  );

  always #5 CLK_A = ~CLK_A;

  int tests = 0;
  int fails = 0;

  logic [13:0] exp_q[$];
  int          model_cnt = 0;
  logic        exp_done = 1'b0;
  logic        exp_ferr = 1'b0;
  logic        exp_werr = 1'b0;
  logic [7:0]  exp_fcnt = '0;
  logic        exp_valid_next = 1'b0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_out = '0;
  logic        rst_prev = 1'b0;
  int          ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 baseline, 1 two-sample, 2 one-sample, 3 delimiter, 4 idle, 5 invalid
  function automatic int kind_of(input logic [31:0] w);
    if (w[31:30] == 2'b01) return 0;
    if (w[31:26] == 6'b001010) return 1;
    if (w[31:26] == 6'b001011) return 2;
    if (w[31:28] == 4'b1101) return 3;
    if (w == 32'hEAAAAAAA) return 4;
    return 5;
  endfunction

  function automatic void push_samples(input logic [31:0] w);
    int k;
    k = kind_of(w);
    if (k == 0) begin
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 13'((w >> (6 * i)) % 64)});
    end else if (k == 1) begin
      exp_q.push_back({1'b0, 13'(w % 8192)});
      exp_q.push_back({1'b0, 13'((w >> 13) % 8192)});
    end else if (k == 2) begin
      exp_q.push_back({1'b0, 13'(w % 8192)});
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 9))
      0, 1, 2: return {2'b01, r[29:0]};
      3, 4:    return {6'b001010, r[25:0]};
      5:       return {6'b001011, r[25:0]};
      6:       return {4'hD, 8'($urandom_range(0, 12)), r[19:0]};
      7:       return 32'hEAAAAAAA;
      8:       return {4'hF, r[27:0]};
      default: return {3'b000, r[28:0]};
    endcase
  endfunction

  // Monitor: outputs and inputs are stable at the falling edge and reflect the next rising edge.
  always @(negedge CLK_A) begin
    logic acc_s;
    logic acc_w;
    int   k;
    if (reset_A) begin
      check("ready_in_reset", 32'(word_ready), 32'd0);
      if (rst_prev) begin
        check("reset_valid", 32'(sample_valid), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset_pulses", {29'd0, frame_done, frame_error, word_error}, 32'd0);
      end
      exp_q.delete();
      model_cnt = 0;
      exp_done = 1'b0;
      exp_ferr = 1'b0;
      exp_werr = 1'b0;
      exp_valid_next = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (rst_prev) check("ready_after_reset", 32'(word_ready), 32'd1);
      if (exp_done || frame_done) begin
        check("frame_done", 32'(frame_done), 32'(exp_done));
        if (exp_done) check("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
      end
      if (exp_ferr || frame_error) check("frame_error", 32'(frame_error), 32'(exp_ferr));
      if (exp_werr || word_error) check("word_error", 32'(word_error), 32'(exp_werr));
      if (exp_valid_next) check("first_sample_latency", 32'(sample_valid), 32'd1);
      if (prev_stall) begin
        check("stall_valid_held", 32'(sample_valid), 32'd1);
        check("stall_sample_held", 32'({sample_bsl, sample_out}), 32'(prev_out));
      end
      if (sample_valid && !sample_ready) check("stall_word_ready", 32'(word_ready), 32'd0);

      acc_s = sample_valid && sample_ready;
      acc_w = word_valid && word_ready;
      if (acc_s) begin
        if (exp_q.size() == 0) check("unexpected_sample", 32'({sample_bsl, sample_out}), 32'hFFFF_FFFF);
        else check("sample", 32'({sample_bsl, sample_out}), 32'(exp_q.pop_front()));
      end

      exp_done = 1'b0;
      exp_ferr = 1'b0;
      exp_werr = 1'b0;
      exp_valid_next = 1'b0;
      k = -1;
      if (acc_w) begin
        k = kind_of(word_in);
        if (k == 3) begin
          exp_done = 1'b1;
          exp_fcnt = 8'(model_cnt);
          exp_ferr = (model_cnt != int'(word_in[27:20]));
          model_cnt = acc_s ? 1 : 0;
        end else if (k == 5) begin
          exp_werr = 1'b1;
        end else if (k <= 2) begin
          push_samples(word_in);
          exp_valid_next = 1'b1;
        end
      end
      if (acc_s && k != 3) model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
      prev_stall = sample_valid && !sample_ready;
      prev_out = {sample_bsl, sample_out};
    end
    rst_prev = reset_A;
  end

  // Sink ready pattern, applied just after each rising edge.
  always @(posedge CLK_A) begin
    #2;
    case (ready_mode)
      0:       sample_ready = 1'b1;
      1:       sample_ready = ($urandom_range(0, 3) != 0);
      default: sample_ready = 1'b0;
    endcase
  end

  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    word_in = w;
    word_valid = 1'b1;
    @(negedge CLK_A);
    while (!word_ready && guard < 200) begin
      @(negedge CLK_A);
      guard++;
    end
    check("send_timeout", 32'(guard >= 200), 32'd0);
    @(posedge CLK_A);
    #1 word_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge CLK_A);
    while ((exp_q.size() != 0 || sample_valid) && guard < 1000) begin
      @(negedge CLK_A);
      guard++;
    end
    check("drain_timeout", 32'(guard >= 1000), 32'd0);
    @(posedge CLK_A);
    #1;
  endtask

  task automatic eight_samples();
    send_word(32'h45103081);
    send_word(32'h28247ABC);
    send_word(32'h2C000FFF);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK_A);
    #1 reset_A = 1'b0;
    @(posedge CLK_A);
    #1;

    // Baseline word, then back-to-back signal words.
    send_word(32'h45103081);
    drain();
    send_word(32'h28247ABC);
    send_word(32'h2C000FFF);
    drain();

    // Sink stall in the middle of a baseline word.
    send_word(32'h45103081);
    @(posedge CLK_A);
    @(posedge CLK_A);
    #1 ready_mode = 2;
    repeat (4) @(posedge CLK_A);
    #1 ready_mode = 0;
    drain();

    // Frame delimiters: clear, then matching and mismatching counts.
    send_word(32'hD0000000);
    eight_samples();
    send_word(32'hD0800000);
    eight_samples();
    send_word(32'hD0900000);
    drain();

    // Idle and invalid words.
    send_word(32'hEAAAAAAA);
    send_word(32'hF0000000);
    repeat (3) @(posedge CLK_A);
    #1;

    // Reset while the third baseline sample is presented.
    send_word(32'h45103081);
    @(posedge CLK_A);
    @(posedge CLK_A);
    #1 reset_A = 1'b1;
    repeat (2) @(posedge CLK_A);
    #1 reset_A = 1'b0;
    repeat (2) @(posedge CLK_A);
    #1;

    // Randomized stream with random sink backpressure and input gaps.
    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge CLK_A);
      if (gap != 0) #1;
      send_word(rand_word());
    end
    ready_mode = 0;
    drain();
    repeat (3) @(posedge CLK_A);
    #1;
    check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
